// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the 3-3-2 pixel layout.
// The pixel draw modules import this package as well.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  typedef logic [POS_W-1:0] pos_t;

  // Bit layout of the 8-bit colour bus: {R[2:0], G[2:0], B[1:0]}.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } color_t;

  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running divider producing a one-clock pixel strobe every CLK_DIV clocks.
// CLK_DIV must be at least 2.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync generation and the blanked, registered 3-3-2 DAC stage.
// Pins lag the counters by one pixel tick so colour and sync stay aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_color,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       en,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b
);

  localparam pos_t H_LAST   = pos_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam pos_t V_LAST   = pos_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam pos_t H_ACT    = pos_t'(H_ACTIVE);
  localparam pos_t V_ACT    = pos_t'(V_ACTIVE);
  localparam pos_t HS_START = pos_t'(H_ACTIVE + H_FP);
  localparam pos_t HS_END   = pos_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam pos_t VS_START = pos_t'(V_ACTIVE + V_FP);
  localparam pos_t VS_END   = pos_t'(V_ACTIVE + V_FP + V_SYNC);

  logic   hs_n;
  logic   vs_n;
  logic   line_end;
  logic   frame_end;
  color_t pix_q;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick)
  );

  assign line_end  = (hpos == H_LAST);
  assign frame_end = line_end && (vpos == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        hpos <= '0;
        vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
    end
  end

  // Pulse lands in the cycle the counters first show (0,0), never at reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && frame_end;
    end
  end

  assign en   = (hpos < H_ACT) && (vpos < V_ACT);
  assign hs_n = !in_window(hpos, HS_START, HS_END);
  assign vs_n = !in_window(vpos, VS_START, VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_tick) begin
      pix_q  <= en ? color_t'(in_color) : '0;
      vga_hs <= hs_n;
      vga_vs <= vs_n;
    end
  end

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
// Pin expectations are queued at each pixel tick and popped when the output stage updates.
module tb_vga_timing_gen;

  localparam int CD  = 3;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 1;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FRAME_CLKS = CD * HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_color = 8'h00;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       en;
  logic       pix_tick;
  logic       frame_start;
  logic       vga_hs;
  logic       vga_vs;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_color    (in_color),
    .hpos        (hpos),
    .vpos        (vpos),
    .en          (en),
    .pix_tick    (pix_tick),
    .frame_start (frame_start),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int         mdiv;
  int         mh;
  int         mv;
  logic       mfs;
  logic [9:0] exp_pins;
  logic [9:0] sb[$];
  bit         pending;

  bit win_en = 1'b0;
  int wstate = 0;
  int wclk   = 0;
  int whs    = 0;
  int wvs    = 0;
  int wcol   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mdiv     = 0;
    mh       = 0;
    mv       = 0;
    mfs      = 1'b0;
    exp_pins = {8'h00, 1'b1, 1'b1};
    sb.delete();
    pending  = 1'b0;
  endtask

  // One clock: check the settled state at the falling edge, then drive the next inputs.
  task automatic step(input logic r, input bit color_from_h, input logic [7:0] c);
    logic       tick;
    logic       en_e;
    logic       hs_e;
    logic       vs_e;
    logic [7:0] col;
    @(negedge clk);
    if (pending) begin
      if (sb.size() > 0) exp_pins = sb.pop_front();
      pending = 1'b0;
    end
    tick = (mdiv == CD - 1);
    en_e = (mh < HA) && (mv < VA);
    hs_e = !((mh >= HA + HF) && (mh < HA + HF + HSY));
    vs_e = !((mv >= VA + VF) && (mv < VA + VF + VSY));
    chk("hpos", 32'(hpos), 32'(mh));
    chk("vpos", 32'(vpos), 32'(mv));
    chk("en", 32'(en), 32'(en_e));
    chk("pix_tick", 32'(pix_tick), 32'(tick));
    chk("frame_start", 32'(frame_start), 32'(mfs));
    chk("color_pins", 32'({vga_r, vga_g, vga_b}), 32'(exp_pins[9:2]));
    chk("vga_hs", 32'(vga_hs), 32'(exp_pins[1]));
    chk("vga_vs", 32'(vga_vs), 32'(exp_pins[0]));

    if (win_en) begin
      if (frame_start === 1'b1) begin
        if (wstate == 0) begin
          wstate = 1; wclk = 0; whs = 0; wvs = 0; wcol = 0;
        end else if (wstate == 1) begin
          wstate = 2;
        end
      end
      if (wstate == 1) begin
        wclk++;
        if (vga_hs === 1'b0) whs++;
        if (vga_vs === 1'b0) wvs++;
        if ({vga_r, vga_g, vga_b} === 8'hE3) wcol++;
      end
    end

    col      = color_from_h ? 8'(mh) : c;
    rst      = r;
    in_color = col;

    if (r) begin
      model_reset();
    end else begin
      if (tick) begin
        sb.push_back({en_e ? col : 8'h00, hs_e, vs_e});
        pending = 1'b1;
      end
      mfs = tick && (mh == HT - 1) && (mv == VT - 1);
      if (tick) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      mdiv = tick ? 0 : mdiv + 1;
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    in_color = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset release with constant colour; measure one full frame window.
    win_en = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLKS + 60; i++) step(1'b0, 1'b0, 8'hE3);
    win_en = 1'b0;
    chk("frame_window_seen", 32'(wstate), 32'd2);
    chk("frame_period", 32'(wclk), 32'(FRAME_CLKS));
    chk("hs_low_clks", 32'(whs), 32'(CD * HSY * VT));
    chk("vs_low_clks", 32'(wvs), 32'(CD * HT * VSY));
    chk("active_color_clks", 32'(wcol), 32'(CD * HA * VA));

    // Pipeline alignment: colour follows hpos.
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 8'h00);

    // Mid-frame reset at a visible pixel, then watch the restart.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      if (mh == 5 && mv == 2 && mdiv == 1) found = 1'b1;
      else step(1'b0, 1'b1, 8'h00);
    end
    chk("midframe_target_reached", 32'(found), 32'd1);
    step(1'b1, 1'b0, 8'hE3);
    for (int i = 0; i < FRAME_CLKS + 30; i++) step(1'b0, 1'b0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
